ppl_pc_gen: RTL and testbench

Parametrised program-counter generator for the pipeline fetch stage. It replaces the externally computed next-PC register with an internal next-PC select: sequential step, branch/jump redirect, or exception vector. Redirects that arrive during a stall are buffered in a one-entry pending slot and applied when the stall releases. The block drives the fetch address and qualifiers straight into instruction memory and the F/D pipeline register.

---
 rtl/ppl_pc_gen.sv | 130 +++++++++++++
 tb/tb_ppl_pc_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ppl_pc_gen.sv
// ppl_pc_gen: fetch-stage program-counter generator with an internal
// next-PC select (sequential step, redirect, exception vector) and a
// one-entry pending slot that holds a redirect arriving during a stall.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   pcContinue  in   advance enable, 0 = stall
//   redirect    in   take redirectPc
//   redirectPc  in   redirect target
//   excReq      in   exception request, load EXC_VECTOR
//   pcOut       out  current fetch address
//   pcValid     out  pcOut is a real fetch
//   redirTaken  out  pcOut was just loaded from a non-sequential target
//   pendValid   out  pending slot occupied
//   alignFault  out  sticky misaligned-redirect flag
//                    (present only with PPL_PC_ALIGN_CHECK_EN)
//
// Optional feature macro: PPL_PC_ALIGN_CHECK_EN

module ppl_pc_gen #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      STEP       = 4,
   parameter logic [WIDTH-1:0] RESET_PC   = {WIDTH{1'b1}} << 2,
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0180)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pcContinue,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirectPc,
   input  logic             excReq,
   output logic [WIDTH-1:0] pcOut,
   output logic             pcValid,
   output logic             redirTaken,
`ifdef PPL_PC_ALIGN_CHECK_EN
   output logic             pendValid,
   output logic             alignFault
`else
   output logic             pendValid
`endif
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] slotPc;
   logic             excFlag;

   logic             alignBad;
   logic             excEff;
   logic             redirEff;
   logic [WIDTH-1:0] nextPc;
   logic             nextNonSeq;

`ifdef PPL_PC_ALIGN_CHECK_EN
   localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - WIDTH'(1);
   logic alignFaultQ;

   // A misaligned redirect is promoted to an exception request.
   assign alignBad   = redirect && ((redirectPc & ALIGN_MASK) != '0);
   assign alignFault = alignFaultQ;
`else
   assign alignBad   = 1'b0;
`endif

   assign excEff    = excReq | alignBad;
   assign redirEff  = redirect & ~alignBad;
   assign pendValid = (state == PEND);

   // Target priority: exception > redirect > pending slot > sequential.
   always_comb begin
      nextPc     = pcOut + STEP_W;
      nextNonSeq = 1'b0;
      if (excEff) begin
         nextPc     = EXC_VECTOR;
         nextNonSeq = 1'b1;
      end else if (redirEff) begin
         nextPc     = redirectPc;
         nextNonSeq = 1'b1;
      end else if (state == PEND) begin
         nextPc     = slotPc;
         nextNonSeq = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pcOut       <= RESET_PC;
         pcValid     <= 1'b0;
         redirTaken  <= 1'b0;
         slotPc      <= '0;
         excFlag     <= 1'b0;
`ifdef PPL_PC_ALIGN_CHECK_EN
         alignFaultQ <= 1'b0;
`endif
      end else begin
`ifdef PPL_PC_ALIGN_CHECK_EN
         if (alignBad)
            alignFaultQ <= 1'b1;
`endif
         if (pcContinue) begin
            pcOut      <= nextPc;
            pcValid    <= 1'b1;
            redirTaken <= nextNonSeq;
            excFlag    <= 1'b0;
            state      <= RUN;
         end else begin
            redirTaken <= 1'b0;
            if (excEff) begin
               slotPc  <= EXC_VECTOR;
               excFlag <= 1'b1;
               state   <= PEND;
            end else if (redirEff && !excFlag) begin
               // Newer redirect replaces an older one, never an exception.
               slotPc  <= redirectPc;
               state   <= PEND;
            end
         end
      end
   end

endmodule

// File: tb/tb_ppl_pc_gen.sv
// tb_ppl_pc_gen: directed self-checking bench for ppl_pc_gen.
// Drives hand-computed vectors and compares registered outputs.

module tb_ppl_pc_gen;

   logic        clk;
   logic        reset;
   logic        pcContinue;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        excReq;
   logic [31:0] pcOut;
   logic        pcValid;
   logic        redirTaken;
   logic        pendValid;
`ifdef PPL_PC_ALIGN_CHECK_EN
   logic        alignFault;
`endif

   int nChecks = 0;
   int nFails  = 0;

   ppl_pc_gen dut (
      .clk        (clk),
      .reset      (reset),
      .pcContinue (pcContinue),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .excReq     (excReq),
      .pcOut      (pcOut),
      .pcValid    (pcValid),
      .redirTaken (redirTaken),
`ifdef PPL_PC_ALIGN_CHECK_EN
      .pendValid  (pendValid),
      .alignFault (alignFault)
`else
      .pendValid  (pendValid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic r,
                        input logic [31:0] rp, input logic e);
      pcContinue = c;
      redirect   = r;
      redirectPc = rp;
      excReq     = e;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      step();
      step();
      check("rst_pc", pcOut, 32'hFFFF_FFFC);
      check("rst_valid", {31'b0, pcValid}, 32'd0);
      check("rst_taken", {31'b0, redirTaken}, 32'd0);
      check("rst_pend", {31'b0, pendValid}, 32'd0);
`ifdef PPL_PC_ALIGN_CHECK_EN
      check("rst_align", {31'b0, alignFault}, 32'd0);
`endif
      reset = 1'b1;
      step();
      check("idle_stall_valid", {31'b0, pcValid}, 32'd0);
      check("idle_stall_pc", pcOut, 32'hFFFF_FFFC);

      // Sequential run from reset
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("seq0_pc", pcOut, 32'h0);
      check("seq0_valid", {31'b0, pcValid}, 32'd1);
      check("seq0_taken", {31'b0, redirTaken}, 32'd0);
      step();
      check("seq1_pc", pcOut, 32'h4);
      step();
      check("seq2_pc", pcOut, 32'h8);
      step();
      step();
      check("seq4_pc", pcOut, 32'h10);

      // Direct redirect
      drive(1'b1, 1'b1, 32'h200, 1'b0);
      step();
      check("redir_pc", pcOut, 32'h200);
      check("redir_taken", {31'b0, redirTaken}, 32'd1);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("redir_next_pc", pcOut, 32'h204);
      check("redir_next_taken", {31'b0, redirTaken}, 32'd0);

      // Stall with two redirects, newest wins
      drive(1'b0, 1'b1, 32'h300, 1'b0);
      step();
      check("stall1_pc", pcOut, 32'h204);
      check("stall1_pend", {31'b0, pendValid}, 32'd1);
      drive(1'b0, 1'b1, 32'h400, 1'b0);
      step();
      check("stall2_pc", pcOut, 32'h204);
      check("stall2_pend", {31'b0, pendValid}, 32'd1);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("release_pc", pcOut, 32'h400);
      check("release_taken", {31'b0, redirTaken}, 32'd1);
      check("release_pend", {31'b0, pendValid}, 32'd0);
      step();
      check("release_next_pc", pcOut, 32'h404);

      // Pended exception is not overwritten by a redirect
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      step();
      check("exc_pend", {31'b0, pendValid}, 32'd1);
      drive(1'b0, 1'b1, 32'h500, 1'b0);
      step();
      check("exc_hold_pc", pcOut, 32'h404);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("exc_release_pc", pcOut, 32'h180);
      check("exc_release_taken", {31'b0, redirTaken}, 32'd1);
      step();
      check("exc_next_pc", pcOut, 32'h184);

      // Same-cycle exception and redirect
      drive(1'b1, 1'b1, 32'h900, 1'b1);
      step();
      check("exc_redir_pc", pcOut, 32'h180);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("exc_redir_next", pcOut, 32'h184);

      // New redirect on release beats the slot, slot cleared
      drive(1'b0, 1'b1, 32'h600, 1'b0);
      step();
      drive(1'b1, 1'b1, 32'h700, 1'b0);
      step();
      check("override_pc", pcOut, 32'h700);
      check("override_pend", {31'b0, pendValid}, 32'd0);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("override_next", pcOut, 32'h704);

      // Wrap from top address
      drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      step();
      check("top_pc", pcOut, 32'hFFFF_FFFC);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("wrap_pc", pcOut, 32'h0);
      check("wrap_taken", {31'b0, redirTaken}, 32'd0);

      // Async reset during PEND
      drive(1'b0, 1'b1, 32'h800, 1'b0);
      step();
      check("pre_rst_pend", {31'b0, pendValid}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("arst_pend", {31'b0, pendValid}, 32'd0);
      check("arst_pc", pcOut, 32'hFFFF_FFFC);
      check("arst_valid", {31'b0, pcValid}, 32'd0);
      step();
      reset = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("post_arst_pc", pcOut, 32'h0);
      check("post_arst_taken", {31'b0, redirTaken}, 32'd0);

      // Misaligned redirect
      step();
      drive(1'b1, 1'b1, 32'h202, 1'b0);
      step();
`ifdef PPL_PC_ALIGN_CHECK_EN
      check("align_pc", pcOut, 32'h180);
      check("align_flag", {31'b0, alignFault}, 32'd1);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("align_sticky", {31'b0, alignFault}, 32'd1);
      check("align_next_pc", pcOut, 32'h184);
      reset = 1'b0;
      #1;
      check("align_clear", {31'b0, alignFault}, 32'd0);
      reset = 1'b1;
`else
      check("unaligned_pc", pcOut, 32'h202);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check("unaligned_next", pcOut, 32'h206);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
